// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time and
// buffers the returned instruction for the decoder, squashing on redirect.
module fetch_unit #(
    parameter int unsigned          XLEN     = 32,
    parameter logic [XLEN-1:0]      RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op,
    output logic [2:0]      func3,
    output logic [6:0]      func7
);

    // state | meaning
    // START | first cycle out of reset, no request yet
    // REQ   | request presented on imem_req
    // WAIT  | request accepted, response pending
    // DROP  | response pending but squashed by a redirect
    // HOLD  | instruction buffered, offered to the decoder
    typedef enum logic [2:0] {
        START = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DROP  = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] buf_q;
    logic [XLEN-1:0] buf_pc_q;
    logic [XLEN-1:0] redirect_pc_aligned;
    logic            req_fire;
    logic            unused_bits;

    assign redirect_pc_aligned = {redirect_pc[XLEN-1:2], 2'b00};
    assign req_fire            = (state_q == REQ) && imem_req_ready;
    assign unused_bits         = ^{redirect_pc[1:0], pc_q[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= START;
            pc_q     <= RESET_PC;
            buf_q    <= '0;
            buf_pc_q <= '0;
        end else begin
            // Redirect wins over every other event; only the next state varies.
            if (redirect_valid) begin
                pc_q <= redirect_pc_aligned;
            end
            case (state_q)
                START: state_q <= REQ;
                REQ: begin
                    if (redirect_valid) begin
                        state_q <= req_fire ? DROP : REQ;
                    end else if (req_fire) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        state_q <= imem_rsp_valid ? REQ : DROP;
                    end else if (imem_rsp_valid) begin
                        buf_q    <= imem_rsp_data;
                        buf_pc_q <= pc_q;
                        pc_q     <= pc_q + XLEN'(4);
                        state_q  <= HOLD;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_q <= REQ;
                    end
                end
                HOLD: begin
                    if (redirect_valid || instr_ready) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= START;
            endcase
        end
    end

    // The address is masked during reset so a nonzero RESET_PC never leaks out.
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = rst ? '0 : {pc_q[XLEN-1:2], 2'b00};
    assign instr_valid    = (state_q == HOLD);
    assign instr          = buf_q;
    assign instr_pc       = buf_pc_q;
    assign op             = buf_q[6:0];
    assign func3          = buf_q[14:12];
    assign func7          = buf_q[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table for the main fetch loop plus
// hand sequences for async reset and the wrapping RESET_PC.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;
    logic [6:0]  op, func7;
    logic [2:0]  func3;

    logic        rst1;
    logic        imem_req_valid1, imem_req_ready1;
    logic [31:0] imem_req_addr1;
    logic        imem_rsp_valid1;
    logic [31:0] imem_rsp_data1;
    logic        redirect_valid1;
    logic [31:0] redirect_pc1;
    logic        instr_valid1, instr_ready1;
    logic [31:0] instr1, instr_pc1;
    logic [6:0]  op1, func71;
    logic [2:0]  func31;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .op(op), .func3(func3), .func7(func7)
    );

    fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst1),
        .imem_req_valid(imem_req_valid1), .imem_req_ready(imem_req_ready1),
        .imem_req_addr(imem_req_addr1),
        .imem_rsp_valid(imem_rsp_valid1), .imem_rsp_data(imem_rsp_data1),
        .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
        .instr_valid(instr_valid1), .instr_ready(instr_ready1),
        .instr(instr1), .instr_pc(instr_pc1),
        .op(op1), .func3(func31), .func7(func71)
    );

    typedef struct {
        logic        rdy;
        logic        rsp;
        logic [31:0] data;
        logic        redir;
        logic [31:0] rpc;
        logic        ir;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic [31:0] e_ipc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rdy, input logic rsp, input logic [31:0] data,
                       input logic redir, input logic [31:0] rpc, input logic ir,
                       input logic e_rv, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_instr, input logic [31:0] e_ipc);
        vec_t v;
        v.rdy = rdy; v.rsp = rsp; v.data = data; v.redir = redir; v.rpc = rpc;
        v.ir = ir; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_instr = e_instr; v.e_ipc = e_ipc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic rdy, input logic rsp, input logic [31:0] data,
                          input logic redir, input logic [31:0] rpc, input logic ir);
        imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rsp_data = data;
        redirect_valid = redir; redirect_pc = rpc; instr_ready = ir;
    endtask

    task automatic chk_all0(input string tag);
        chk({tag, " instr"},    instr,    32'h0);
        chk({tag, " instr_pc"}, instr_pc, 32'h0);
        chk({tag, " op"},       {25'h0, op},    32'h0);
        chk({tag, " func3"},    {29'h0, func3}, 32'h0);
        chk({tag, " func7"},    {25'h0, func7}, 32'h0);
    endtask

    initial begin
        logic [31:0] ei;
        rst = 1'b1; rst1 = 1'b1;
        drive0(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        imem_req_ready1 = 1'b0; imem_rsp_valid1 = 1'b0; imem_rsp_data1 = 32'h0;
        redirect_valid1 = 1'b0; redirect_pc1 = 32'h0; instr_ready1 = 1'b0;

        //   rdy  rsp  data          redir rpc           ir    e_rv  e_addr        e_iv  e_instr       e_ipc
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0,        32'h0);     // START
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0);     // REQ 0
        add(1'b0, 1'b1, 32'h00A12083, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0000, 1'b0, 32'h0,        32'h0);     // WAIT
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'h00A12083, 32'h0);     // HOLD x5
        add(1'b1, 1'b1, 32'h11111111, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'h00A12083, 32'h0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'h00A12083, 32'h0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'h00A12083, 32'h0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 1'b1, 32'h00A12083, 32'h0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0004, 1'b1, 32'h00A12083, 32'h0);     // consume
        add(1'b0, 1'b1, 32'h22222222, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,        32'h0);     // REQ stalled
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0004, 1'b0, 32'h0,        32'h0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0,        32'h0);     // WAIT idle
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h103,     1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0,        32'h0);     // redirect -> DROP
        add(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        32'h0);     // stale rsp
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0,        32'h0);
        add(1'b0, 1'b1, 32'h12345678, 1'b1, 32'h200,     1'b1, 1'b0, 32'h0000_0100, 1'b0, 32'h0,        32'h0);     // redirect + rsp
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0,        32'h0);
        add(1'b0, 1'b1, 32'hFE010113, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0200, 1'b0, 32'h0,        32'h0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h300,     1'b1, 1'b0, 32'h0000_0204, 1'b1, 32'hFE010113, 32'h200);   // HOLD redirect
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h42,      1'b0, 1'b1, 32'h0000_0300, 1'b0, 32'h0,        32'h0);     // REQ redirect, no accept
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h80,      1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0,        32'h0);     // accept + redirect
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h90,      1'b0, 1'b0, 32'h0000_0080, 1'b0, 32'h0,        32'h0);     // DROP redirect
        add(1'b0, 1'b1, 32'h0,        1'b1, 32'hA0,      1'b0, 1'b0, 32'h0000_0090, 1'b0, 32'h0,        32'h0);     // DROP rsp+redirect
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_00A0, 1'b0, 32'h0,        32'h0);
        add(1'b0, 1'b1, 32'h40B50533, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_00A0, 1'b0, 32'h0,        32'h0);
        add(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,       1'b1, 1'b0, 32'h0000_00A4, 1'b1, 32'h40B50533, 32'hA0);
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_00A4, 1'b0, 32'h0,        32'h0);

        @(negedge clk); #1;
        chk("rst req_valid",   {31'h0, imem_req_valid}, 32'h0);
        chk("rst instr_valid", {31'h0, instr_valid},    32'h0);
        chk("rst addr",        imem_req_addr,           32'h0);
        chk_all0("rst");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive0(tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].redir, tbl[i].rpc, tbl[i].ir);
            #1;
            chk($sformatf("row%0d req_valid", i),   {31'h0, imem_req_valid}, {31'h0, tbl[i].e_rv});
            chk($sformatf("row%0d addr", i),        imem_req_addr,           tbl[i].e_addr);
            chk($sformatf("row%0d instr_valid", i), {31'h0, instr_valid},    {31'h0, tbl[i].e_iv});
            if (tbl[i].e_iv) begin
                ei = tbl[i].e_instr;
                chk($sformatf("row%0d instr", i),    instr,            ei);
                chk($sformatf("row%0d instr_pc", i), instr_pc,         tbl[i].e_ipc);
                chk($sformatf("row%0d op", i),       {25'h0, op},      {25'h0, ei[6:0]});
                chk($sformatf("row%0d func3", i),    {29'h0, func3},   {29'h0, ei[14:12]});
                chk($sformatf("row%0d func7", i),    {25'h0, func7},   {25'h0, ei[31:25]});
            end
            @(negedge clk);
        end

        // Hand-decoded fields of the first test word (lw x1,10(x2)).
        chk("lw op",    {25'h0, 7'b0000011}, {25'h0, 7'h03});

        // Async reset in WAIT, then a stale response after release.
        drive0(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("wait addr", imem_req_addr, 32'h0000_00A4);
        #2 rst = 1'b1;
        #1;
        chk("async req_valid",   {31'h0, imem_req_valid}, 32'h0);
        chk("async instr_valid", {31'h0, instr_valid},    32'h0);
        chk("async addr",        imem_req_addr,           32'h0);
        chk_all0("async");
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b0, 1'b1, 32'hBADBAD00, 1'b0, 32'h0, 1'b1);
        #1;
        chk("post-rst start rv", {31'h0, imem_req_valid}, 32'h0);
        @(negedge clk);
        drive0(1'b0, 1'b1, 32'hBADBAD01, 1'b0, 32'h0, 1'b1);
        #1;
        chk("post-rst req rv",   {31'h0, imem_req_valid}, 32'h1);
        chk("post-rst req addr", imem_req_addr,           32'h0);
        chk("post-rst iv",       {31'h0, instr_valid},    32'h0);
        @(negedge clk);
        drive0(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        #1;
        chk("stale ignored rv", {31'h0, imem_req_valid}, 32'h1);
        chk("stale ignored iv", {31'h0, instr_valid},    32'h0);
        @(negedge clk);
        drive0(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        chk("post-rst wait rv", {31'h0, imem_req_valid}, 32'h0);

        // Wrapping reset PC on the second instance.
        #1;
        chk("wrap rst addr masked", imem_req_addr1, 32'h0);
        chk("wrap rst rv", {31'h0, imem_req_valid1}, 32'h0);
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        chk("wrap start rv", {31'h0, imem_req_valid1}, 32'h0);
        @(negedge clk);
        imem_req_ready1 = 1'b1;
        #1;
        chk("wrap req rv",   {31'h0, imem_req_valid1}, 32'h1);
        chk("wrap req addr", imem_req_addr1,           32'hFFFF_FFFC);
        @(negedge clk);
        imem_req_ready1 = 1'b0; imem_rsp_valid1 = 1'b1; imem_rsp_data1 = 32'h0000_0013;
        @(negedge clk);
        imem_rsp_valid1 = 1'b0; instr_ready1 = 1'b1;
        #1;
        chk("wrap iv",       {31'h0, instr_valid1}, 32'h1);
        chk("wrap instr",    instr1,                32'h0000_0013);
        chk("wrap instr_pc", instr_pc1,             32'hFFFF_FFFC);
        chk("wrap op",       {25'h0, op1},          32'h13);
        chk("wrap next addr", imem_req_addr1,       32'h0);
        @(negedge clk);
        instr_ready1 = 1'b0;
        #1;
        chk("wrap req2 rv",   {31'h0, imem_req_valid1}, 32'h1);
        chk("wrap req2 addr", imem_req_addr1,           32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
